// File: rtl/bus_cmd_bridge.sv
// bus_cmd_bridge: byte-stream command front end that issues single 32-bit
// read/write transactions on the memory bus and streams back status/data.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   rx_valid_in/rx_data_in/rx_ready_out   : command byte stream in
//   tx_valid_out/tx_data_out/tx_ready_in  : response byte stream out
//   address_out/read_out/write_out/write_mask_out/write_value_out : bus request
//   read_value_in/ready_in/fault_in        : bus completion
//   busy_out                    : high whenever a command is in progress
module bus_cmd_bridge #(
  parameter int BUS_TIMEOUT = 1024,
  parameter int CMD_TIMEOUT = 36000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid_in,
  input  logic [7:0]  rx_data_in,
  output logic        rx_ready_out,
  output logic        tx_valid_out,
  output logic [7:0]  tx_data_out,
  input  logic        tx_ready_in,
  output logic [31:0] address_out,
  output logic        read_out,
  output logic        write_out,
  output logic [3:0]  write_mask_out,
  output logic [31:0] write_value_out,
  input  logic [31:0] read_value_in,
  input  logic        ready_in,
  input  logic        fault_in,
  output logic        busy_out
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_BUS  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [7:0] OP_READ   = 8'h50;
  localparam logic [7:0] RSP_OK    = 8'h06;
  localparam logic [7:0] RSP_FAULT = 8'h15;
  localparam logic [7:0] RSP_BADOP = 8'h3F;

  localparam int CW = $clog2(CMD_TIMEOUT + 1);
  localparam int BW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_TIMEOUT - 1);
  localparam logic [CW-1:0] CMD_MAX  = '1;
  localparam logic [BW-1:0] BUS_LAST = BW'(BUS_TIMEOUT - 1);

  logic [2:0]    state;
  logic          is_write;
  logic [3:0]    mask;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [1:0]    byte_cnt;
  logic [CW-1:0] cmd_idle;
  logic [BW-1:0] bus_wait;
  // Response bytes are queued MSB-first; the top byte is always the one on tx.
  logic [39:0]   resp_buf;
  logic [2:0]    resp_left;

  logic rx_fire;
  logic tx_fire;
  logic req;

  assign rx_ready_out = (state == S_IDLE) || (state == S_ADDR) || (state == S_DATA);
  assign busy_out     = (state != S_IDLE);
  assign rx_fire      = rx_valid_in && rx_ready_out;
  assign tx_fire      = tx_valid_out && tx_ready_in;
  assign tx_data_out  = resp_buf[39:32];
  assign req          = read_out || write_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      is_write        <= 1'b0;
      mask            <= 4'h0;
      addr            <= 32'h0;
      wdata           <= 32'h0;
      byte_cnt        <= 2'd0;
      cmd_idle        <= '0;
      bus_wait        <= '0;
      resp_buf        <= 40'h0;
      resp_left       <= 3'd0;
      tx_valid_out    <= 1'b0;
      address_out     <= 32'h0;
      read_out        <= 1'b0;
      write_out       <= 1'b0;
      write_mask_out  <= 4'h0;
      write_value_out <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_fire) begin
            byte_cnt <= 2'd0;
            cmd_idle <= '0;
            addr     <= 32'h0;
            wdata    <= 32'h0;
            if (rx_data_in == OP_READ) begin
              is_write <= 1'b0;
              mask     <= 4'h0;
              state    <= S_ADDR;
            end else if (rx_data_in[7:4] == 4'hA && rx_data_in[3:0] != 4'h0) begin
              is_write <= 1'b1;
              mask     <= rx_data_in[3:0];
              state    <= S_ADDR;
            end else begin
              resp_buf     <= {RSP_BADOP, 32'h0};
              resp_left    <= 3'd1;
              tx_valid_out <= 1'b1;
              state        <= S_RESP;
            end
          end
        end

        S_ADDR, S_DATA: begin
          if (rx_fire) begin
            cmd_idle <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (state == S_ADDR) addr  <= {addr[23:0], rx_data_in};
            else                 wdata <= {wdata[23:0], rx_data_in};
            if (byte_cnt == 2'd3) begin
              if (state == S_ADDR && is_write) state <= S_DATA;
              else                             state <= S_BUS;
            end
          end else if (cmd_idle >= CMD_LAST) begin
            // Stalled partial command: drop it silently.
            cmd_idle <= '0;
            byte_cnt <= 2'd0;
            state    <= S_IDLE;
          end else if (cmd_idle != CMD_MAX) begin
            cmd_idle <= cmd_idle + 1'b1;
          end
        end

        S_BUS: begin
          if (!req) begin
            // First BUS cycle: launch the registered request.
            address_out     <= addr;
            write_value_out <= wdata;
            write_mask_out  <= is_write ? mask : 4'h0;
            write_out       <= is_write;
            read_out        <= !is_write;
            bus_wait        <= '0;
          end else if (ready_in || bus_wait == BUS_LAST) begin
            address_out     <= 32'h0;
            write_value_out <= 32'h0;
            write_mask_out  <= 4'h0;
            write_out       <= 1'b0;
            read_out        <= 1'b0;
            bus_wait        <= '0;
            tx_valid_out    <= 1'b1;
            state           <= S_RESP;
            // A timeout (no ready) reports the same status as a decode fault.
            if (!ready_in || fault_in) begin
              resp_buf  <= {RSP_FAULT, 32'h0};
              resp_left <= 3'd1;
            end else if (is_write) begin
              resp_buf  <= {RSP_OK, 32'h0};
              resp_left <= 3'd1;
            end else begin
              resp_buf  <= {RSP_OK, read_value_in};
              resp_left <= 3'd5;
            end
          end else begin
            bus_wait <= bus_wait + 1'b1;
          end
        end

        S_RESP: begin
          if (tx_fire) begin
            resp_buf  <= {resp_buf[31:0], 8'h00};
            resp_left <= resp_left - 3'd1;
            if (resp_left == 3'd1) begin
              tx_valid_out <= 1'b0;
              state        <= S_IDLE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cmd_bridge.sv
// tb_bus_cmd_bridge: directed command sequences against bus_cmd_bridge with a
// command-level model (expected bus ops and response bytes) checked by one
// monitor every cycle, plus literal checks of key results.
module tb_bus_cmd_bridge;
  localparam int BUS_TO = 8;
  localparam int CMD_TO = 16;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    bit          rd;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;
  } bus_op_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid_in;
  logic [7:0]  rx_data_in;
  logic        rx_ready_out;
  logic        tx_valid_out;
  logic [7:0]  tx_data_out;
  logic        tx_ready_in;
  logic [31:0] address_out;
  logic        read_out;
  logic        write_out;
  logic [3:0]  write_mask_out;
  logic [31:0] write_value_out;
  logic [31:0] read_value_in;
  logic        ready_in;
  logic        fault_in;
  logic        busy_out;

  int n_cmp = 0;
  int n_bad = 0;

  bq_t     exp_tx;
  bq_t     tx_log;
  bus_op_t exp_bus[$];
  bus_op_t cur;
  bit      cur_vld = 0;
  int      req_len = 0;
  int      last_len = 0;
  logic [31:0] last_addr = 32'h0;
  logic [31:0] last_wdata = 32'h0;
  logic [3:0]  last_mask = 4'h0;

  int          rsp_wait = 0;
  bit          rsp_hang = 0;
  bit          rsp_fault = 0;
  bit          rsp_noise = 0;
  logic [31:0] rsp_data = 32'h0;
  bit          stray = 0;
  bit          sink_toggle = 0;

  bus_cmd_bridge #(.BUS_TIMEOUT(BUS_TO), .CMD_TIMEOUT(CMD_TO)) dut (
    .clk(clk), .reset(reset),
    .rx_valid_in(rx_valid_in), .rx_data_in(rx_data_in), .rx_ready_out(rx_ready_out),
    .tx_valid_out(tx_valid_out), .tx_data_out(tx_data_out), .tx_ready_in(tx_ready_in),
    .address_out(address_out), .read_out(read_out), .write_out(write_out),
    .write_mask_out(write_mask_out), .write_value_out(write_value_out),
    .read_value_in(read_value_in), .ready_in(ready_in), .fault_in(fault_in),
    .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Command-level model: what a command must produce on the bus and on tx.
  function automatic void model(input bq_t cmd, input bit hang, input bit fault,
                                input int wt, input logic [31:0] rdata);
    bus_op_t    op;
    logic [7:0] oc;
    int         need;
    oc = cmd[0];
    op.wdata = 32'h0;
    if (oc == 8'h50) begin
      op.rd = 1'b1; op.mask = 4'h0; need = 5;
    end else if (oc[7:4] == 4'hA && oc[3:0] != 4'h0) begin
      op.rd = 1'b0; op.mask = oc[3:0]; need = 9;
    end else begin
      exp_tx.push_back(8'h3F);
      return;
    end
    if (cmd.size() < need) return;
    op.addr = {cmd[1], cmd[2], cmd[3], cmd[4]};
    if (!op.rd) op.wdata = {cmd[5], cmd[6], cmd[7], cmd[8]};
    op.len = hang ? BUS_TO : wt + 1;
    exp_bus.push_back(op);
    if (hang || fault) exp_tx.push_back(8'h15);
    else begin
      exp_tx.push_back(8'h06);
      if (op.rd) for (int i = 3; i >= 0; i--) exp_tx.push_back(rdata[8*i +: 8]);
    end
  endfunction

  task automatic step(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid_in = 1'b1;
    rx_data_in  = b;
    while (!rx_ready_out && n < 300) begin @(posedge clk); #1; n++; end
    if (n >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL rx_accept: byte %0h never accepted", b);
    end
    @(posedge clk); #1;
    rx_valid_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_tx.size() != 0 || exp_bus.size() != 0 || busy_out) && n < 600) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 600) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: pending tx %0d bus %0d busy %0b", exp_tx.size(), exp_bus.size(), busy_out);
      exp_tx.delete();
      exp_bus.delete();
    end
  endtask

  task automatic run_cmd(input bq_t cmd, input bit hang, input bit fault, input int wt,
                         input logic [31:0] rdata, input int gap, output int lat);
    rsp_hang = hang; rsp_fault = fault; rsp_wait = wt; rsp_data = rdata;
    tx_log.delete();
    model(cmd, hang, fault, wt, rdata);
    foreach (cmd[i]) begin
      send_byte(cmd[i]);
      if (gap > 0 && i < cmd.size() - 1) step(gap);
    end
    lat = 1;
    while (!tx_valid_out && lat < 400) begin @(posedge clk); #1; lat++; end
    drain();
  endtask

  task automatic check_log(input string name, input bq_t exp);
    check({name, "_count"}, 72'(tx_log.size()), 72'(exp.size()));
    foreach (exp[i]) if (i < tx_log.size()) check(name, 72'(tx_log[i]), 72'(exp[i]));
  endtask

  // Bus responder: ready after rsp_wait cycles, or never when hanging.
  initial begin : responder
    int rcnt = 0;
    ready_in = 1'b0; fault_in = 1'b0; read_value_in = 32'h0;
    forever begin
      @(posedge clk); #1;
      ready_in = 1'b0; fault_in = 1'b0;
      if (stray) begin
        ready_in = 1'b1; fault_in = 1'b1; rcnt = 0;
      end else if ((read_out || write_out) && !rsp_hang) begin
        if (rcnt == rsp_wait) begin
          ready_in = 1'b1; fault_in = rsp_fault; read_value_in = rsp_data; rcnt = 0;
        end else begin
          fault_in = rsp_noise; rcnt++;
        end
      end else begin
        fault_in = rsp_noise && (read_out || write_out);
        rcnt = 0;
      end
    end
  end

  initial begin : sink
    tx_ready_in = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_ready_in = sink_toggle ? !tx_ready_in : 1'b1;
    end
  end

  initial begin : monitor
    bit         req_prev = 0;
    bit         stall_prev = 0;
    logic [7:0] stall_dat = 8'h0;
    bit         req;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 0;
      end else begin
        req = read_out || write_out;
        if (tx_valid_out && tx_ready_in) begin
          tx_log.push_back(tx_data_out);
          if (exp_tx.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL tx_unexpected: got %0h, none expected", tx_data_out);
          end else check("tx_byte", 72'(tx_data_out), 72'(exp_tx.pop_front()));
        end
        if (stall_prev) check("tx_hold", 72'({tx_valid_out, tx_data_out}), 72'({1'b1, stall_dat}));
        stall_prev = tx_valid_out && !tx_ready_in;
        stall_dat  = tx_data_out;
        if (req || tx_valid_out) check("rx_blocked", 72'({rx_ready_out, busy_out}), 72'(2'b01));
        if (req) begin
          if (!req_prev) begin
            req_len = 0;
            last_addr = address_out; last_mask = write_mask_out; last_wdata = write_value_out;
            if (exp_bus.size() == 0) begin
              cur_vld = 0; n_cmp++; n_bad++;
              $display("FAIL bus_unexpected: addr %0h rd %0b wr %0b", address_out, read_out, write_out);
            end else begin
              cur = exp_bus.pop_front(); cur_vld = 1;
            end
          end
          req_len++;
          if (cur_vld)
            check("bus_fields",
                  {2'b00, read_out, write_out, write_mask_out, address_out, (cur.rd ? 32'h0 : write_value_out)},
                  {2'b00, cur.rd, !cur.rd, cur.mask, cur.addr, cur.wdata});
        end else if (req_prev) begin
          last_len = req_len;
          if (cur_vld && cur.len > 0) check("req_len", 72'(req_len), 72'(cur.len));
          cur_vld = 0;
        end
        req_prev = req;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    bq_t     c;
    int      lat;
    bus_op_t op;
    int      n;
    reset = 1'b1; rx_valid_in = 1'b0; rx_data_in = 8'h00;
    step(3);
    check("rst_ctrl",
          72'({read_out, write_out, write_mask_out, tx_valid_out, tx_data_out, rx_ready_out, busy_out}),
          72'({1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b1, 1'b0}));
    check("rst_bus", 72'({address_out, write_value_out}), 72'(0));
    reset = 1'b0;
    step(2);

    // Write with 2 wait states; fault_in noise while not ready.
    rsp_noise = 1;
    c = '{8'hA3, 8'h00, 8'h00, 8'h00, 8'h40, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_cmd(c, 0, 0, 2, 32'h0, 0, lat);
    rsp_noise = 0;
    c = '{8'h06}; check_log("wr_tx", c);
    check("wr_bus", {4'h0, last_addr, last_mask, last_wdata}, {4'h0, 32'h00000040, 4'h3, 32'hDEADBEEF});
    check("wr_len", 72'(last_len), 72'(3));

    // Read, zero wait, tx_ready toggling.
    sink_toggle = 1;
    c = '{8'h50, 8'h00, 8'h03, 8'h00, 8'h00};
    run_cmd(c, 0, 0, 0, 32'h12345678, 0, lat);
    sink_toggle = 0;
    check("rd_latency", 72'(lat), 72'(3));
    check("rd_len", 72'(last_len), 72'(1));
    check("rd_addr", 72'(last_addr), 72'(32'h00030000));
    c = '{8'h06, 8'h12, 8'h34, 8'h56, 8'h78}; check_log("rd_tx", c);

    // Stray ready/fault while idle must do nothing.
    tx_log.delete();
    stray = 1; step(2); stray = 0; step(3);
    check("stray_idle", 72'({busy_out, rx_ready_out}), 72'(2'b01));
    check("stray_tx", 72'(tx_log.size()), 72'(0));

    // Faulting read.
    c = '{8'h50, 8'h00, 8'h05, 8'h00, 8'h00};
    run_cmd(c, 0, 1, 0, 32'hCAFEF00D, 0, lat);
    c = '{8'h15}; check_log("flt_tx", c);
    step(1);
    check("flt_busy", 72'(busy_out), 72'(0));

    // Bus timeout, then a normal read.
    c = '{8'h50, 8'h00, 8'h00, 8'h01, 8'h00};
    run_cmd(c, 1, 0, 0, 32'h0, 0, lat);
    c = '{8'h15}; check_log("to_tx", c);
    check("to_len", 72'(last_len), 72'(BUS_TO));
    c = '{8'h50, 8'h00, 8'h00, 8'h00, 8'h10};
    run_cmd(c, 0, 0, 1, 32'hA5A55A5A, 0, lat);
    c = '{8'h06, 8'hA5, 8'hA5, 8'h5A, 8'h5A}; check_log("to_rd_tx", c);

    // Invalid opcodes.
    c = '{8'h7E};
    run_cmd(c, 0, 0, 0, 32'h0, 0, lat);
    c = '{8'h3F}; check_log("op7e_tx", c);
    c = '{8'hA0};
    run_cmd(c, 0, 0, 0, 32'h0, 0, lat);
    c = '{8'h3F}; check_log("opa0_tx", c);

    // Partial command abandoned by the idle timeout.
    tx_log.delete();
    send_byte(8'h50);
    send_byte(8'h00);
    check("ct_busy", 72'(busy_out), 72'(1));
    step(20);
    check("ct_idle", 72'({busy_out, rx_ready_out}), 72'(2'b01));
    check("ct_tx", 72'(tx_log.size()), 72'(0));

    // Gaps shorter than the idle timeout keep the command alive.
    c = '{8'hAF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h01, 8'h02, 8'h03, 8'h04};
    run_cmd(c, 0, 0, 0, 32'h0, 12, lat);
    c = '{8'h06}; check_log("gap_tx", c);
    check("gap_bus", {4'h0, last_addr, last_mask, last_wdata}, {4'h0, 32'h12345678, 4'hF, 32'h01020304});

    // Reset during a hung write.
    tx_log.delete();
    rsp_hang = 1;
    op.rd = 1'b0; op.mask = 4'hC; op.addr = 32'h00000100; op.wdata = 32'h11223344; op.len = 0;
    exp_bus.push_back(op);
    c = '{8'hAC, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    foreach (c[i]) send_byte(c[i]);
    n = 0;
    while (!write_out && n < 20) begin step(1); n++; end
    step(2);
    check("rst_pre", 72'(write_out), 72'(1));
    reset = 1'b1;
    step(1);
    check("rst_mid",
          72'({write_out, read_out, busy_out, tx_valid_out, rx_ready_out, write_mask_out}),
          72'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0}));
    check("rst_mid_bus", 72'({address_out, write_value_out}), 72'(0));
    reset = 1'b0;
    rsp_hang = 0;
    step(4);
    check("rst_no_retry", 72'({tx_log.size(), busy_out}), 72'(0));
    c = '{8'h50, 8'h00, 8'h00, 8'h00, 8'h20};
    run_cmd(c, 0, 0, 0, 32'h0BADF00D, 0, lat);
    c = '{8'h06, 8'h0B, 8'hAD, 8'hF0, 8'h0D}; check_log("post_rst_tx", c);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
